// File: rtl/mem_access_sequencer_pkg.sv
// mem_access_sequencer_pkg: shared FSM encoding and constants for the memory access sequencer
// Contents: state_t (IDLE/REQ/DONE/ERR), ERR_DATA_DEF (load result after a bus abort),
//           ALIGN_MASK (byte-offset bits that must be zero for a word access)
package mem_access_sequencer_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;
    localparam logic [1:0] ALIGN_MASK = 2'b11;
endpackage

// File: rtl/mem_access_sequencer_bus_timeout_counter.sv
// mem_access_sequencer_bus_timeout_counter: counts cycles spent waiting for a bus ack
// Ports: clk_i, reset_i (sync, active high); clear restarts the count; enable counts one wait cycle;
//        expired is high during the TIMEOUT-th enabled cycle since the last clear
module mem_access_sequencer_bus_timeout_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] count;
    // count holds the number of completed wait cycles, so the current cycle is number count+1
    assign expired = enable && count == CW'(TIMEOUT - 1);
    always_ff @(posedge clk_i) begin
        if (reset_i || clear)
            count <= '0;
        else if (enable && count != CW'(TIMEOUT))
            count <= count + 1'b1;
    end
endmodule

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: turns a memory-stage load/store into a req/ack bus transaction and stalls the datapath
// Ports: clk_i, reset_i (sync, active high)
//        memRead_i/memWrite_i/addr_i/writeData_i : access request from the memory stage
//        readData_o : load result, held until the next load completes
//        stall_o    : freezes the datapath while an access is launched or in flight
//        busReq_o/busWe_o/busAddr_o/busWData_o/busAck_i/busRData_i : data bus handshake
//        busErr_o   : sticky timeout flag; misaligned_o : one-cycle pulse for an unaligned access
module mem_access_sequencer
    import mem_access_sequencer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TIMEOUT = 64,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              memRead_i,
    input  logic              memWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] writeData_i,
    output logic [DATA_W-1:0] readData_o,
    output logic              stall_o,
    output logic              busReq_o,
    output logic              busWe_o,
    output logic [ADDR_W-1:0] busAddr_o,
    output logic [DATA_W-1:0] busWData_o,
    input  logic              busAck_i,
    input  logic [DATA_W-1:0] busRData_i,
    output logic              busErr_o,
    output logic              misaligned_o
);
    state_t state;
    logic access, aligned, launch, expired;
    assign access = memRead_i | memWrite_i;
    assign aligned = (addr_i[1:0] & ALIGN_MASK) == 2'b00;
    assign launch = state == S_IDLE && access && aligned;
    // DONE deliberately drops stall so the datapath steps past the finished instruction
    assign stall_o = launch || state == S_REQ || state == S_ERR;
    mem_access_sequencer_bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear   (launch),
        .enable  (state == S_REQ),
        .expired (expired)
    );
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state        <= S_IDLE;
            readData_o   <= '0;
            busReq_o     <= 1'b0;
            busWe_o      <= 1'b0;
            busAddr_o    <= '0;
            busWData_o   <= '0;
            busErr_o     <= 1'b0;
            misaligned_o <= 1'b0;
        end else begin
            misaligned_o <= state == S_IDLE && access && !aligned;
            case (state)
                S_IDLE: if (launch) begin
                    busAddr_o  <= addr_i;
                    busWData_o <= writeData_i;
                    busWe_o    <= memWrite_i;
                    busReq_o   <= 1'b1;
                    state      <= S_REQ;
                end
                // an ack in the final wait cycle still wins over the timeout
                S_REQ: if (busAck_i) begin
                    busReq_o <= 1'b0;
                    if (!busWe_o) readData_o <= busRData_i;
                    state <= S_DONE;
                end else if (expired) begin
                    busReq_o <= 1'b0;
                    state    <= S_ERR;
                end
                S_ERR: begin
                    busErr_o <= 1'b1;
                    if (!busWe_o) readData_o <= ERR_DATA;
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer: directed self-checking bench for mem_access_sequencer
module tb_mem_access_sequencer;
    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        memRead_i = 1'b0, memWrite_i = 1'b0;
    logic [31:0] addr_i = '0, writeData_i = '0;
    logic [31:0] readData_o;
    logic        stall_o, busReq_o, busWe_o;
    logic [31:0] busAddr_o, busWData_o;
    logic        busAck_i = 1'b0;
    logic [31:0] busRData_i = 32'h55AA55AA;
    logic        busErr_o, misaligned_o;
    int errors = 0;
    int checks = 0;
    int stall_cnt, req_cycles;
    logic stable;

    always #5 clk = ~clk;

    mem_access_sequencer dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .memRead_i    (memRead_i),
        .memWrite_i   (memWrite_i),
        .addr_i       (addr_i),
        .writeData_i  (writeData_i),
        .readData_o   (readData_o),
        .stall_o      (stall_o),
        .busReq_o     (busReq_o),
        .busWe_o      (busWe_o),
        .busAddr_o    (busAddr_o),
        .busWData_o   (busWData_o),
        .busAck_i     (busAck_i),
        .busRData_i   (busRData_i),
        .busErr_o     (busErr_o),
        .misaligned_o (misaligned_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one access from posedge+1; acks in the ack_wait-th REQ cycle (0 = never).
    // Returns at the negedge of the first non-stalled cycle (DONE) with inputs still held.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input int ack_wait, input logic [31:0] rdata,
                              output int sc, output int rc, output logic st);
        logic done;
        memRead_i = rd; memWrite_i = wr; addr_i = a; writeData_i = wd;
        sc = 0; rc = 0; st = 1'b1; done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c > 0 && !stall_o) begin
                done = 1'b1;
                break;
            end
            if (stall_o) sc++;
            if (busReq_o) begin
                rc++;
                if (busAddr_o !== a || busWe_o !== wr || (wr && busWData_o !== wd)) st = 1'b0;
                if (rc == ack_wait) begin
                    busAck_i = 1'b1;
                    busRData_i = rdata;
                end
            end
            @(posedge clk); #1;
            busAck_i = 1'b0;
            busRData_i = 32'h55AA55AA;
        end
        if (!done) chk("access_bounded", 32'(done), 1);
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
        memRead_i = 1'b0; memWrite_i = 1'b0; addr_i = '0; writeData_i = '0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        chk("rst_stall", 32'(stall_o), 0);
        chk("rst_req", 32'(busReq_o), 0);
        chk("rst_rdata", readData_o, 0);
        chk("rst_err", 32'(busErr_o), 0);
        chk("rst_mis", 32'(misaligned_o), 0);
        @(posedge clk); #1;

        // 1: load, ack in first REQ cycle
        run_access(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'h12345678, stall_cnt, req_cycles, stable);
        chk("t1_stall", stall_cnt, 2);
        chk("t1_reqcyc", req_cycles, 1);
        chk("t1_stable", 32'(stable), 1);
        chk("t1_rdata", readData_o, 32'h12345678);
        chk("t1_req_done", 32'(busReq_o), 0);
        next_cycle();

        // 2: store, ack in fifth REQ cycle
        run_access(1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 5, 32'hA5A5A5A5, stall_cnt, req_cycles, stable);
        chk("t2_stall", stall_cnt, 6);
        chk("t2_reqcyc", req_cycles, 5);
        chk("t2_stable", 32'(stable), 1);
        chk("t2_we", 32'(busWe_o), 1);
        chk("t2_rdata_kept", readData_o, 32'h12345678);
        chk("t2_err", 32'(busErr_o), 0);
        next_cycle();

        // 3: load never acked -> timeout after 64 REQ cycles, then ERR
        run_access(1'b1, 1'b0, 32'h104, 32'h0, 0, 32'h0, stall_cnt, req_cycles, stable);
        chk("t3_reqcyc", req_cycles, 64);
        chk("t3_stall", stall_cnt, 66);
        chk("t3_err", 32'(busErr_o), 1);
        chk("t3_rdata", readData_o, 32'hDEADBEEF);
        chk("t3_req", 32'(busReq_o), 0);
        next_cycle();

        // 4: misaligned load
        memRead_i = 1'b1; addr_i = 32'h102;
        @(negedge clk);
        chk("t4_stall", 32'(stall_o), 0);
        chk("t4_mis_early", 32'(misaligned_o), 0);
        next_cycle();
        @(negedge clk);
        chk("t4_mis", 32'(misaligned_o), 1);
        chk("t4_req", 32'(busReq_o), 0);
        chk("t4_stall_after", 32'(stall_o), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_mis_pulse", 32'(misaligned_o), 0);
        @(posedge clk); #1;

        // 6: read and write together -> store wins, load data untouched
        run_access(1'b1, 1'b1, 32'h300, 32'h13572468, 2, 32'h11111111, stall_cnt, req_cycles, stable);
        chk("t6_stall", stall_cnt, 3);
        chk("t6_stable", 32'(stable), 1);
        chk("t6_we", 32'(busWe_o), 1);
        chk("t6_rdata_kept", readData_o, 32'hDEADBEEF);
        chk("t6_err_sticky", 32'(busErr_o), 1);
        next_cycle();

        // 5: reset in REQ, then a late ack
        memRead_i = 1'b1; addr_i = 32'h400;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_req", 32'(busReq_o), 1);
        chk("t5_addr", busAddr_o, 32'h400);
        reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0; memRead_i = 1'b0; addr_i = '0;
        @(negedge clk);
        chk("t5_req_rst", 32'(busReq_o), 0);
        chk("t5_stall_rst", 32'(stall_o), 0);
        chk("t5_addr_rst", busAddr_o, 0);
        chk("t5_err_rst", 32'(busErr_o), 0);
        chk("t5_rdata_rst", readData_o, 0);
        busAck_i = 1'b1; busRData_i = 32'h99999999;
        @(posedge clk); #1;
        busAck_i = 1'b0; busRData_i = 32'h55AA55AA;
        @(negedge clk);
        chk("t5_late_rdata", readData_o, 0);
        chk("t5_late_req", 32'(busReq_o), 0);
        chk("t5_late_stall", 32'(stall_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
